spi_txn_arbiter: RTL and testbench

- Shares the single SPI transfer engine (Send_and_Receive) between three requesters: init/config writer, host register access, periodic data-read scheduler.
- Latches the winner's command word, pulses the engine's go, waits for the engine's end, and returns a per-requester done pulse.
- A watchdog ends a stuck transfer and raises a sticky error.
- Sits between the sensor controller logic and the SPI engine; all requesters run on iSPI_CLK.

---
 rtl/spi_txn_arbiter.sv | 131 +++++++++++++
 tb/tb_spi_txn_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI transfer engine between init, host and periodic requesters.
// Init has strict priority; host and periodic alternate round-robin.
module spi_txn_arbiter #(
    parameter int CMD_W       = 17,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic             iSPI_CLK,
    input  logic             iRSTN,
    input  logic [2:0]       iREQ,
    input  logic [CMD_W-1:0] iCMD0,
    input  logic [CMD_W-1:0] iCMD1,
    input  logic [CMD_W-1:0] iCMD2,
    output logic [2:0]       oGNT,
    output logic [2:0]       oDONE,
    output logic             oERR,
    output logic             oTIMEOUT,
    input  logic             iCLR_ERR,
    output logic             oBUSY,
    output logic             oSPI_GO,
    output logic [CMD_W-1:0] oDATA_P2S,
    input  logic             iSPI_END
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_END,
        DONE
    } state_t;

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

    state_t           state;
    logic             end_q;
    logic             rr_host;
    logic             cool;
    logic [15:0]      cnt;
    logic [15:0]      cnt_inc;
    logic [2:0]       pick;
    logic [CMD_W-1:0] pick_cmd;

    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    always_comb begin
        pick = 3'b000;
        if (iREQ[0])
            pick = 3'b001;
        else if (iREQ[1] && (rr_host || !iREQ[2]))
            pick = 3'b010;
        else if (iREQ[2])
            pick = 3'b100;
    end

    always_comb begin
        pick_cmd = '0;
        unique case (1'b1)
            pick[0]: pick_cmd = iCMD0;
            pick[1]: pick_cmd = iCMD1;
            pick[2]: pick_cmd = iCMD2;
            default: pick_cmd = '0;
        endcase
    end

    always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state     <= IDLE;
            end_q     <= 1'b0;
            rr_host   <= 1'b1;
            cool      <= 1'b0;
            cnt       <= '0;
            oGNT      <= '0;
            oDONE     <= '0;
            oERR      <= 1'b0;
            oTIMEOUT  <= 1'b0;
            oBUSY     <= 1'b0;
            oSPI_GO   <= 1'b0;
            oDATA_P2S <= '0;
        end else begin
            end_q   <= iSPI_END;
            oSPI_GO <= 1'b0;
            oDONE   <= '0;
            oERR    <= 1'b0;
            if (iCLR_ERR)
                oTIMEOUT <= 1'b0;
            case (state)
                IDLE: begin
                    // Cooldown lets a finished requester drop iREQ first
                    if (cool) begin
                        cool <= 1'b0;
                    end else if (|pick) begin
                        oDATA_P2S <= pick_cmd;
                        oGNT      <= pick;
                        oBUSY     <= 1'b1;
                        oSPI_GO   <= 1'b1;
                        state     <= LAUNCH;
                        if (pick[1])
                            rr_host <= 1'b0;
                        else if (pick[2])
                            rr_host <= 1'b1;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT_END;
                end
                WAIT_END: begin
                    if (iSPI_END && !end_q) begin
                        oDONE <= oGNT;
                        state <= DONE;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc >= TO_LIM) begin
                            oDONE    <= oGNT;
                            oERR     <= 1'b1;
                            oTIMEOUT <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    oGNT  <= '0;
                    oBUSY <= 1'b0;
                    cool  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: priority, round-robin,
// stale end level, watchdog, command hold and mid-transfer reset.
module tb_spi_txn_arbiter;

    localparam int CW = 17;
    localparam int TO = 48;

    localparam logic [CW-1:0] C0 = 17'h10001;
    localparam logic [CW-1:0] C1 = 17'h02222;
    localparam logic [CW-1:0] C2 = 17'h13333;

    logic          clk = 1'b0;
    logic          iRSTN;
    logic [2:0]    iREQ;
    logic [CW-1:0] iCMD0, iCMD1, iCMD2;
    logic [2:0]    oGNT, oDONE;
    logic          oERR, oTIMEOUT, iCLR_ERR, oBUSY, oSPI_GO;
    logic [CW-1:0] oDATA_P2S;
    logic          iSPI_END;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_txn_arbiter #(.CMD_W(CW), .TIMEOUT_CYC(TO)) dut (
        .iSPI_CLK (clk),
        .iRSTN    (iRSTN),
        .iREQ     (iREQ),
        .iCMD0    (iCMD0),
        .iCMD1    (iCMD1),
        .iCMD2    (iCMD2),
        .oGNT     (oGNT),
        .oDONE    (oDONE),
        .oERR     (oERR),
        .oTIMEOUT (oTIMEOUT),
        .iCLR_ERR (iCLR_ERR),
        .oBUSY    (oBUSY),
        .oSPI_GO  (oSPI_GO),
        .oDATA_P2S(oDATA_P2S),
        .iSPI_END (iSPI_END)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_go(input string tag);
        int i;
        i = 0;
        while (!oSPI_GO && i < 60) begin
            step();
            i++;
        end
        chk({tag, "_go"}, 32'(oSPI_GO), 32'd1);
    endtask

    task automatic txn(input string tag, input logic [2:0] g,
                       input logic [CW-1:0] d, input int lat,
                       input logic [2:0] req_after);
        wait_go(tag);
        chk({tag, "_gnt"}, 32'(oGNT), 32'(g));
        chk({tag, "_data"}, 32'(oDATA_P2S), 32'(d));
        repeat (lat) step();
        iSPI_END = 1'b1;
        step();
        chk({tag, "_done"}, 32'(oDONE), 32'(g));
        chk({tag, "_gnt_done"}, 32'(oGNT), 32'(g));
        iSPI_END = 1'b0;
        iREQ = req_after;
        step();
        step();
        chk({tag, "_cool"}, 32'(oBUSY), 32'd0);
    endtask

    initial begin
        iRSTN    = 1'b0;
        iREQ     = '0;
        iCMD0    = C0;
        iCMD1    = C1;
        iCMD2    = C2;
        iCLR_ERR = 1'b0;
        iSPI_END = 1'b0;
        repeat (2) step();
        chk("rst_gnt", 32'(oGNT), 32'd0);
        chk("rst_done", 32'(oDONE), 32'd0);
        chk("rst_err", 32'(oERR), 32'd0);
        chk("rst_to", 32'(oTIMEOUT), 32'd0);
        chk("rst_busy", 32'(oBUSY), 32'd0);
        chk("rst_go", 32'(oSPI_GO), 32'd0);
        chk("rst_data", 32'(oDATA_P2S), 32'd0);
        iRSTN = 1'b1;
        step();

        // single init transfer, end edge 40 cycles after launch
        iCMD0 = 17'h02C09;
        iREQ  = 3'b001;
        step();
        chk("t1_go", 32'(oSPI_GO), 32'd1);
        chk("t1_gnt", 32'(oGNT), 32'd1);
        chk("t1_data", 32'(oDATA_P2S), 32'h02C09);
        chk("t1_busy", 32'(oBUSY), 32'd1);
        step();
        chk("t1_go_pulse", 32'(oSPI_GO), 32'd0);
        repeat (38) step();
        iSPI_END = 1'b1;
        step();
        chk("t1_done", 32'(oDONE), 32'd1);
        chk("t1_err", 32'(oERR), 32'd0);
        iSPI_END = 1'b0;
        iREQ = '0;
        step();
        chk("t1_done_pulse", 32'(oDONE), 32'd0);
        chk("t1_idle", 32'(oBUSY), 32'd0);
        chk("t1_gnt_off", 32'(oGNT), 32'd0);
        iCMD0 = C0;
        step();

        // all three held: init, then host/periodic alternate
        iREQ = 3'b111;
        txn("rr_i", 3'b001, C0, 3, 3'b110);
        txn("rr_h1", 3'b010, C1, 2, 3'b110);
        txn("rr_p1", 3'b100, C2, 4, 3'b110);
        txn("rr_h2", 3'b010, C1, 1, 3'b110);
        txn("rr_p2", 3'b100, C2, 2, 3'b000);

        // end level already high must not complete the transfer
        iSPI_END = 1'b1;
        step();
        step();
        iREQ = 3'b110;
        wait_go("stale");
        chk("stale_gnt", 32'(oGNT), 32'd2);
        repeat (5) step();
        chk("stale_nodone", 32'(oDONE), 32'd0);
        chk("stale_busy", 32'(oBUSY), 32'd1);
        iSPI_END = 1'b0;
        step();
        step();
        iSPI_END = 1'b1;
        step();
        chk("stale_done", 32'(oDONE), 32'd2);
        iSPI_END = 1'b0;
        iREQ = '0;
        step();
        step();

        // watchdog
        iREQ = 3'b010;
        wait_go("to1");
        repeat (TO) step();
        chk("to_early", 32'(oDONE), 32'd0);
        step();
        chk("to_done", 32'(oDONE), 32'd2);
        chk("to_err", 32'(oERR), 32'd1);
        chk("to_flag", 32'(oTIMEOUT), 32'd1);
        iREQ = '0;
        step();
        chk("to_err_pulse", 32'(oERR), 32'd0);
        chk("to_sticky", 32'(oTIMEOUT), 32'd1);
        iCLR_ERR = 1'b1;
        step();
        chk("to_clr", 32'(oTIMEOUT), 32'd0);
        iCLR_ERR = 1'b0;
        iREQ = 3'b010;
        wait_go("to2");
        repeat (TO) step();
        iCLR_ERR = 1'b1;
        step();
        chk("to_set_wins", 32'(oTIMEOUT), 32'd1);
        chk("to2_err", 32'(oERR), 32'd1);
        iCLR_ERR = 1'b0;
        iREQ = '0;
        step();
        chk("to2_sticky", 32'(oTIMEOUT), 32'd1);
        iCLR_ERR = 1'b1;
        step();
        iCLR_ERR = 1'b0;
        step();

        // command and request change after grant
        iCMD1 = 17'h0ABCD;
        iREQ  = 3'b010;
        wait_go("hold");
        chk("hold_data0", 32'(oDATA_P2S), 32'h0ABCD);
        iCMD1 = 17'h1FFFF;
        iREQ  = '0;
        repeat (3) step();
        chk("hold_data1", 32'(oDATA_P2S), 32'h0ABCD);
        iSPI_END = 1'b1;
        step();
        chk("hold_done", 32'(oDONE), 32'd2);
        chk("hold_data2", 32'(oDATA_P2S), 32'h0ABCD);
        iSPI_END = 1'b0;
        iCMD1 = C1;
        step();
        step();

        // reset during WAIT_END
        iREQ = 3'b100;
        wait_go("rst_mid");
        repeat (3) step();
        iRSTN = 1'b0;
        #1;
        chk("rm_gnt", 32'(oGNT), 32'd0);
        chk("rm_busy", 32'(oBUSY), 32'd0);
        chk("rm_data", 32'(oDATA_P2S), 32'd0);
        chk("rm_go", 32'(oSPI_GO), 32'd0);
        step();
        step();
        chk("rm_nodone", 32'(oDONE), 32'd0);
        iRSTN = 1'b1;
        txn("post_rst", 3'b100, C2, 2, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
